// File: rtl/ai_topk_sorter.sv
// Streaming top-K ranker: buffers packet sums in a FIFO, keeps a sorted (value, index)
// list by insertion, then emits the ranked list over a valid/ready stream.
module ai_topk_sorter #(
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 8,
  parameter int K          = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [IDX_W-1:0]  packet_size,
  input  logic              mode,
  input  logic [DATA_W-1:0] sum_in,
  input  logic              sum_rdy,
  output logic              sum_full,
  output logic              overflow,
  output logic [DATA_W-1:0] sum_out,
  output logic [IDX_W-1:0]  idx_out,
  output logic              sum_out_rdy,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] K_M1 = IDX_W'(K - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT, S_DONE} state_t;
  state_t state;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, push, pop;

  logic [IDX_W-1:0]  ps_q, cnt, last_rank;
  logic              mode_q;
  logic [PW-1:0]     ptr;

  logic [DATA_W-1:0] lv [K];
  logic [IDX_W-1:0]  li [K];
  logic [K-1:0]      vld;
  logic [DATA_W-1:0] nv [K];
  logic [IDX_W-1:0]  ni [K];
  logic [K-1:0]      nvld;
  logic [DATA_W-1:0] head;

  assign empty    = (wr_ptr == rd_ptr);
  assign sum_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = (state == S_COLLECT) && !empty && (cnt != ps_q) && !init;
  // A full FIFO still takes a write when the same cycle pops a word.
  assign push     = sum_rdy && !init && (!sum_full || pop);
  assign head     = mem[rd_ptr[AW-1:0]];

  assign last_rank = (ps_q <= K_M1) ? (ps_q - IDX_W'(1)) : K_M1;
  assign busy      = (state == S_COLLECT) || (state == S_EMIT);
  assign state_dbg = state;
  assign sum_out   = sum_out_rdy ? lv[ptr] : '0;
  assign idx_out   = sum_out_rdy ? li[ptr] : '0;

  // Insert head before the first slot it strictly beats; ties keep the earlier arrival ahead.
  always_comb begin
    logic seen;
    logic beats;
    logic [K-1:0] taken;
    nv    = lv;
    ni    = li;
    nvld  = vld;
    seen  = 1'b0;
    taken = '0;
    for (int j = 0; j < K; j++) begin
      beats    = !vld[j] || (mode_q ? (head > lv[j]) : (head < lv[j]));
      taken[j] = seen;
      if (!seen && beats) begin
        nv[j]   = head;
        ni[j]   = cnt;
        nvld[j] = 1'b1;
      end
      seen = seen | beats;
    end
    for (int j = 1; j < K; j++) begin
      if (taken[j]) begin
        nv[j]   = lv[j-1];
        ni[j]   = li[j-1];
        nvld[j] = vld[j-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sum_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      ps_q        <= '0;
      mode_q      <= 1'b0;
      cnt         <= '0;
      ptr         <= '0;
      sum_out_rdy <= 1'b0;
      done        <= 1'b0;
      vld         <= '0;
      for (int j = 0; j < K; j++) begin
        lv[j] <= '0;
        li[j] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (init) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (sum_rdy && sum_full && !pop) overflow <= 1'b1;
      end

      if (init) begin
        state       <= S_COLLECT;
        ps_q        <= packet_size;
        mode_q      <= mode;
        cnt         <= '0;
        ptr         <= '0;
        sum_out_rdy <= 1'b0;
        vld         <= '0;
      end else begin
        case (state)
          S_IDLE: ;
          S_COLLECT: begin
            if (pop) begin
              lv  <= nv;
              li  <= ni;
              vld <= nvld;
              cnt <= cnt + IDX_W'(1);
            end else if (cnt == ps_q) begin
              if (ps_q == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state       <= S_EMIT;
                ptr         <= '0;
                sum_out_rdy <= 1'b1;
              end
            end
          end
          S_EMIT: begin
            if (sum_out_rdy && out_ready) begin
              if (IDX_W'(ptr) == last_rank) begin
                sum_out_rdy <= 1'b0;
                state       <= S_DONE;
                done        <= 1'b1;
              end else begin
                ptr <= ptr + PW'(1);
              end
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ai_topk_sorter.sv
// Bench for ai_topk_sorter: directed scenarios plus random packets, checked against
// a stable-selection ranking model of each packet.
module tb_ai_topk_sorter;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int K  = 4;
  localparam int FD = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init = 1'b0;
  logic [IW-1:0] packet_size = '0;
  logic          mode = 1'b0;
  logic [DW-1:0] sum_in = '0;
  logic          sum_rdy = 1'b0;
  logic          sum_full, overflow, sum_out_rdy, busy, done;
  logic          out_ready = 1'b0;
  logic [DW-1:0] sum_out;
  logic [IW-1:0] idx_out;
  logic [1:0]    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW+IW-1:0] exp_q[$];
  logic [DW-1:0]    pv[$];

  ai_topk_sorter #(.DATA_W(DW), .IDX_W(IW), .K(K), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .init(init), .packet_size(packet_size), .mode(mode),
    .sum_in(sum_in), .sum_rdy(sum_rdy), .sum_full(sum_full), .overflow(overflow),
    .sum_out(sum_out), .idx_out(idx_out), .sum_out_rdy(sum_out_rdy),
    .out_ready(out_ready), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ranking: repeatedly pick the best unused entry, lowest index on ties.
  function automatic void build_expected(input logic m);
    int n;
    int lim;
    int best;
    bit used[];
    n = pv.size();
    used = new[n];
    exp_q.delete();
    lim = (n < K) ? n : K;
    for (int r = 0; r < lim; r++) begin
      best = -1;
      for (int i = 0; i < n; i++)
        if (!used[i] && (best < 0 || (m ? (pv[i] > pv[best]) : (pv[i] < pv[best]))))
          best = i;
      used[best] = 1'b1;
      exp_q.push_back({IW'(best), pv[best]});
    end
  endfunction

  // driver tasks (all called at a falling edge)
  task automatic do_init(input int ps, input logic m);
    init = 1'b1;
    packet_size = IW'(ps);
    mode = m;
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic write_word(input logic [DW-1:0] v);
    sum_in = v;
    sum_rdy = 1'b1;
    @(negedge clk);
    sum_rdy = 1'b0;
  endtask

  task automatic collect(input int bp, input string tag);
    int  lat = -1;
    int  emit_cyc = 0;
    int  cyc = 0;
    int  dn = 0;
    bit  extra = 1'b0;
    while (exp_q.size() > 0 && cyc < 400) begin
      if (sum_out_rdy) begin
        if (lat < 0) begin
          lat = cyc;
          check({tag, "_lat"}, 64'(lat <= 4), 64'd1);
        end
        case (bp)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = (emit_cyc >= 2) && (emit_cyc % 2 == 0);
        endcase
        emit_cyc++;
        check({tag, "_out"}, 64'({idx_out, sum_out}), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;
    for (int w = 0; w < 4; w++) begin
      if (done) dn++;
      if (sum_out_rdy) extra = 1'b1;
      @(negedge clk);
    end
    check({tag, "_done_once"}, 64'(dn), 64'd1);
    check({tag, "_no_extra"}, 64'(extra), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic run_pv(input logic m, input int bp, input string tag);
    do_init(pv.size(), m);
    foreach (pv[i]) write_word(pv[i]);
    build_expected(m);
    collect(bp, tag);
  endtask

  task automatic run_random(input int n, input logic m, input int bp, input int vmax, input string tag);
    logic [DW-1:0] v;
    pv.delete();
    do_init(n, m);
    for (int i = 0; i < n; i++) begin
      v = (vmax == 0) ? DW'($urandom) : DW'($urandom_range(0, vmax));
      pv.push_back(v);
      write_word(v);
    end
    build_expected(m);
    collect(bp, tag);
  endtask

  initial begin
    int dn;
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_sum_out", 64'(sum_out), 64'd0);
    check("rst_idx_out", 64'(idx_out), 64'd0);
    check("rst_rdy", 64'(sum_out_rdy), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_full", 64'(sum_full), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    pv = '{5, 9, 1, 9, 7, 3};
    run_pv(1'b1, 0, "t1_max");
    run_pv(1'b0, 0, "t2_min");
    run_pv(1'b1, 2, "t4_bp");
    pv = '{40, 10};
    run_pv(1'b1, 0, "t3_two");

    // empty packet
    do_init(0, 1'b1);
    dn = 0;
    seen = 1'b0;
    for (int w = 0; w < 3; w++) begin
      if (done) dn++;
      if (sum_out_rdy) seen = 1'b1;
      @(negedge clk);
    end
    check("empty_done", 64'(dn), 64'd1);
    check("empty_no_rdy", 64'(seen), 64'd0);
    check("empty_idle", 64'(busy), 64'd0);

    // fill FIFO in IDLE, then flush with init
    for (int i = 0; i < 17; i++) begin
      write_word(DW'(100 + i));
      if (i == 14) check("fifo_not_full_15", 64'(sum_full), 64'd0);
      if (i == 15) begin
        check("fifo_full_16", 64'(sum_full), 64'd1);
        check("fifo_no_ovf_16", 64'(overflow), 64'd0);
      end
      if (i == 16) check("fifo_ovf_17", 64'(overflow), 64'd1);
    end
    do_init(2, 1'b1);
    check("flush_full", 64'(sum_full), 64'd0);
    check("flush_ovf", 64'(overflow), 64'd0);
    pv = '{40, 10};
    foreach (pv[i]) write_word(pv[i]);
    build_expected(1'b1);
    collect(0, "t5_flush");

    // restart mid-collect; the write coinciding with init must be dropped
    do_init(6, 1'b1);
    write_word(5);
    write_word(9);
    write_word(1);
    init = 1'b1;
    packet_size = 2;
    mode = 1'b1;
    sum_in = 99;
    sum_rdy = 1'b1;
    @(negedge clk);
    init = 1'b0;
    sum_rdy = 1'b0;
    check("reinit_rdy", 64'(sum_out_rdy), 64'd0);
    check("reinit_busy", 64'(busy), 64'd1);
    pv = '{2, 8};
    foreach (pv[i]) write_word(pv[i]);
    build_expected(1'b1);
    collect(0, "t6_reinit");

    // random packets, leftover words beyond the packet stay queued until the next init
    for (int t = 0; t < 30; t++) begin
      run_random($urandom_range(1, 24), 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                 ($urandom_range(0, 1) == 1) ? 15 : 0, "rnd");
      for (int e = $urandom_range(0, 3); e > 0; e--) write_word(DW'($urandom));
    end
    run_random(255, 1'b0, 1, 7, "max_pkt");

    // asynchronous reset during EMIT
    do_init(6, 1'b1);
    for (int i = 0; i < 6; i++) write_word(DW'($urandom_range(1, 1000)));
    seen = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      if (sum_out_rdy) seen = 1'b1;
      else @(negedge clk);
    end
    check("emit_reached", 64'(seen), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_sum_out", 64'(sum_out), 64'd0);
    check("arst_idx_out", 64'(idx_out), 64'd0);
    check("arst_rdy", 64'(sum_out_rdy), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
